multi_axis_step_ctrl: RTL and testbench

- Parametrised successor to the Control/Pulse pair: one block drives N stepper axes with step (pu), direction (dr) and enable (mf) outputs.
- After reset, homes every axis in sequence against its stop switch, then executes absolute-position move commands.
- Commands arrive through a single pending slot; a newer command overwrites an unexecuted one.
- Sits between the command decoder (binary target, axis index) and the motor driver pins.

---
 rtl/step_ctrl_pkg.sv | 33 +++
 rtl/step_timer.sv | 28 ++
 rtl/multi_axis_step_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multi_axis_step_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the multi-axis stepper controller: state codes,
// axis-index width helper and the command/position types used on the
// decoder side of the block.
package step_ctrl_pkg;

  localparam int DEF_N_AXIS = 6;
  localparam int DEF_POS_W  = 10;

  // Width of an axis index; a single-axis build still needs one bit.
  function automatic int axisW(input int nAxis);
    return (nAxis > 1) ? $clog2(nAxis) : 1;
  endfunction

  localparam int AXIS_W = axisW(DEF_N_AXIS);

  // Controller states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t HOME_SEL = 3'd0;
  localparam state_t HOME_HI  = 3'd1;
  localparam state_t HOME_LO  = 3'd2;
  localparam state_t IDLE     = 3'd3;
  localparam state_t LOAD     = 3'd4;
  localparam state_t STEP_HI  = 3'd5;
  localparam state_t STEP_LO  = 3'd6;

  typedef logic [DEF_POS_W-1:0] pos_t;

  typedef struct packed {
    logic [AXIS_W-1:0] axis;
    pos_t              target;
  } cmd_t;

endpackage

// File: rtl/step_timer.sv
// Half-period down-counter shared by the homing and move states.
// load_i restarts a HALF_PER-cycle interval; tick_o marks its last cycle.
module step_timer #(
  parameter int HALF_PER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic tick_o
);

  localparam int CNT_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load_i)
      cnt_q <= CNT_W'(HALF_PER - 1);
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/multi_axis_step_ctrl.sv
// N-axis stepper controller: homes each axis against its stop switch, then
// executes absolute moves taken from a single pending command slot.
// Optional macro POS_LIMIT_EN clamps incoming targets to MAX_POS.
module multi_axis_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int N_AXIS   = DEF_N_AXIS,
  parameter int POS_W    = DEF_POS_W,
  parameter int HALF_PER = 4,
  parameter int HOME_MAX = 1023,
  parameter int MAX_POS  = 1000
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  input  logic [axisW(N_AXIS)-1:0]      cmd_axis,
  input  logic [POS_W-1:0]              cmd_target,
  input  logic [N_AXIS-1:0]             stop,
  output logic [N_AXIS-1:0]             pu,
  output logic [N_AXIS-1:0]             dr,
  output logic [N_AXIS-1:0]             mf,
  output logic                          busy,
  output logic                          init_done,
  output logic [N_AXIS-1:0]             home_err,
  output logic                          pend_ovr,
  output logic [N_AXIS*POS_W-1:0]       cur_pos
);

  localparam int AW   = axisW(N_AXIS);
  localparam int HC_W = $clog2(HOME_MAX + 1);

  logic [N_AXIS-1:0]             stopMeta_q, stopSync_q;
  state_t                        state_q, state_d;
  logic [AW-1:0]                 homeAxis_q, homeAxis_d;
  logic [AW-1:0]                 moveAxis_q, moveAxis_d;
  logic [N_AXIS-1:0][POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]              remain_q, remain_d;
  logic [HC_W-1:0]               homeCnt_q, homeCnt_d;
  logic                          abort_q, abort_d;
  logic [N_AXIS-1:0]             pu_q, pu_d, dr_q, dr_d, mf_q, mf_d;
  logic [N_AXIS-1:0]             homeErr_q, homeErr_d;
  logic                          initDone_q, initDone_d;
  logic                          pendOvr_q, pendOvr_d;
  logic                          slotFull_q, slotFull_d;
  logic [AW-1:0]                 slotAxis_q, slotAxis_d;
  logic [POS_W-1:0]              slotTarget_q, slotTarget_d;
  logic                          timerLoad, timerTick;
  logic                          cmdOk;
  logic [POS_W-1:0]              cmdTarget;

  assign cmdOk = cmd_valid && (32'(cmd_axis) < N_AXIS);

`ifdef POS_LIMIT_EN
  assign cmdTarget = (cmd_target > POS_W'(MAX_POS)) ? POS_W'(MAX_POS) : cmd_target;
`else
  assign cmdTarget = cmd_target;
  // The soft travel limit only matters when clamping is compiled in.
  localparam int unusedMaxPos = MAX_POS;
`endif

  step_timer #(.HALF_PER(HALF_PER)) uTimer (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .load_i (timerLoad),
    .tick_o (timerTick)
  );

  // Two-flop synchroniser for the asynchronous home switches.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      stopMeta_q <= '0;
      stopSync_q <= '0;
    end else begin
      stopMeta_q <= stop;
      stopSync_q <= stopMeta_q;
    end
  end

  // Next-state logic for the pending slot, homing sequence and moves.
  always_comb begin
    logic finishHome;
    logic revStop;
    state_d      = state_q;
    homeAxis_d   = homeAxis_q;
    moveAxis_d   = moveAxis_q;
    pos_d        = pos_q;
    remain_d     = remain_q;
    homeCnt_d    = homeCnt_q;
    abort_d      = abort_q;
    pu_d         = pu_q;
    dr_d         = dr_q;
    mf_d         = mf_q;
    homeErr_d    = homeErr_q;
    initDone_d   = initDone_q;
    slotFull_d   = slotFull_q;
    slotAxis_d   = slotAxis_q;
    slotTarget_d = slotTarget_q;
    timerLoad    = 1'b0;
    finishHome   = 1'b0;
    revStop      = stopSync_q[moveAxis_q] & ~dr_q[moveAxis_q];

    // LOAD reads the old slot contents this cycle, so a same-cycle write
    // simply refills the slot and is not an overwrite.
    pendOvr_d = cmdOk & slotFull_q & (state_q != LOAD);
    if (cmdOk) begin
      slotFull_d   = 1'b1;
      slotAxis_d   = cmd_axis;
      slotTarget_d = cmdTarget;
    end else if (state_q == LOAD) begin
      slotFull_d = 1'b0;
    end

    case (state_q)
      HOME_SEL: begin
        mf_d             = '0;
        mf_d[homeAxis_q] = 1'b1;
        dr_d[homeAxis_q] = 1'b0;
        pu_d             = '0;
        pu_d[homeAxis_q] = 1'b1;
        homeCnt_d        = '0;
        timerLoad        = 1'b1;
        state_d          = HOME_HI;
      end
      HOME_HI: begin
        if (stopSync_q[homeAxis_q]) begin
          finishHome = 1'b1;
        end else if (timerTick) begin
          pu_d[homeAxis_q] = 1'b0;
          homeCnt_d        = homeCnt_q + 1'b1;
          timerLoad        = 1'b1;
          state_d          = HOME_LO;
        end
      end
      HOME_LO: begin
        if (stopSync_q[homeAxis_q]) begin
          finishHome = 1'b1;
        end else if (timerTick) begin
          if (homeCnt_q == HC_W'(HOME_MAX)) begin
            homeErr_d[homeAxis_q] = 1'b1;
            finishHome            = 1'b1;
          end else begin
            pu_d[homeAxis_q] = 1'b1;
            timerLoad        = 1'b1;
            state_d          = HOME_HI;
          end
        end
      end
      IDLE: begin
        if (slotFull_q && initDone_q)
          state_d = LOAD;
      end
      LOAD: begin
        moveAxis_d = slotAxis_q;
        abort_d    = 1'b0;
        if (slotTarget_q == pos_q[slotAxis_q]) begin
          state_d = IDLE;
        end else begin
          dr_d[slotAxis_q] = (slotTarget_q > pos_q[slotAxis_q]);
          remain_d         = (slotTarget_q > pos_q[slotAxis_q]) ?
                             slotTarget_q - pos_q[slotAxis_q] :
                             pos_q[slotAxis_q] - slotTarget_q;
          mf_d             = '0;
          mf_d[slotAxis_q] = 1'b1;
          pu_d[slotAxis_q] = 1'b1;
          timerLoad        = 1'b1;
          state_d          = STEP_HI;
        end
      end
      STEP_HI: begin
        if (revStop)
          abort_d = 1'b1;
        if (timerTick) begin
          pos_d[moveAxis_q] = dr_q[moveAxis_q] ? pos_q[moveAxis_q] + 1'b1 :
                                                 pos_q[moveAxis_q] - 1'b1;
          remain_d          = remain_q - 1'b1;
          pu_d[moveAxis_q]  = 1'b0;
          timerLoad         = 1'b1;
          state_d           = STEP_LO;
        end
      end
      STEP_LO: begin
        if (timerTick) begin
          if (abort_q || revStop) begin
            pos_d[moveAxis_q] = '0;
            mf_d[moveAxis_q]  = 1'b0;
            state_d           = IDLE;
          end else if (remain_q != '0) begin
            pu_d[moveAxis_q] = 1'b1;
            timerLoad        = 1'b1;
            state_d          = STEP_HI;
          end else begin
            mf_d[moveAxis_q] = 1'b0;
            state_d          = IDLE;
          end
        end else if (revStop) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = HOME_SEL;
    endcase

    if (finishHome) begin
      pos_d[homeAxis_q] = '0;
      mf_d[homeAxis_q]  = 1'b0;
      pu_d[homeAxis_q]  = 1'b0;
      if (homeAxis_q == AW'(N_AXIS - 1)) begin
        initDone_d = 1'b1;
        state_d    = IDLE;
      end else begin
        homeAxis_d = homeAxis_q + 1'b1;
        state_d    = HOME_SEL;
      end
    end
  end

  // State registers; reset aborts everything and restarts homing at axis 0.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOME_SEL;
      homeAxis_q   <= '0;
      moveAxis_q   <= '0;
      pos_q        <= '0;
      remain_q     <= '0;
      homeCnt_q    <= '0;
      abort_q      <= 1'b0;
      pu_q         <= '0;
      dr_q         <= '0;
      mf_q         <= '0;
      homeErr_q    <= '0;
      initDone_q   <= 1'b0;
      pendOvr_q    <= 1'b0;
      slotFull_q   <= 1'b0;
      slotAxis_q   <= '0;
      slotTarget_q <= '0;
    end else begin
      state_q      <= state_d;
      homeAxis_q   <= homeAxis_d;
      moveAxis_q   <= moveAxis_d;
      pos_q        <= pos_d;
      remain_q     <= remain_d;
      homeCnt_q    <= homeCnt_d;
      abort_q      <= abort_d;
      pu_q         <= pu_d;
      dr_q         <= dr_d;
      mf_q         <= mf_d;
      homeErr_q    <= homeErr_d;
      initDone_q   <= initDone_d;
      pendOvr_q    <= pendOvr_d;
      slotFull_q   <= slotFull_d;
      slotAxis_q   <= slotAxis_d;
      slotTarget_q <= slotTarget_d;
    end
  end

  assign pu        = pu_q;
  assign dr        = dr_q;
  assign mf        = mf_q;
  assign home_err  = homeErr_q;
  assign init_done = initDone_q;
  assign pend_ovr  = pendOvr_q;
  assign cur_pos   = pos_q;
  assign busy      = (state_q != IDLE) | slotFull_q | ~initDone_q;

endmodule

// File: tb/tb_multi_axis_step_ctrl.sv
// Self-checking bench for multi_axis_step_ctrl: homing order and timeout,
// absolute moves, pending-slot overwrite, stop handling and reset abort.
module tb_multi_axis_step_ctrl;
  import step_ctrl_pkg::*;

  localparam int N_AXIS   = 6;
  localparam int POS_W    = 10;
  localparam int HALF_PER = 4;
  localparam int HOME_MAX = 1023;
  localparam int MAX_POS  = 1000;
  localparam int AW       = axisW(N_AXIS);

  logic                    sysclk;
  logic                    rst_n;
  logic                    cmd_valid;
  logic [AW-1:0]           cmd_axis;
  logic [POS_W-1:0]        cmd_target;
  logic [N_AXIS-1:0]       stop;
  logic [N_AXIS-1:0]       pu, dr, mf, home_err;
  logic                    busy, init_done, pend_ovr;
  logic [N_AXIS*POS_W-1:0] cur_pos;

  multi_axis_step_ctrl #(
    .N_AXIS(N_AXIS), .POS_W(POS_W), .HALF_PER(HALF_PER),
    .HOME_MAX(HOME_MAX), .MAX_POS(MAX_POS)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_axis(cmd_axis),
    .cmd_target(cmd_target), .stop(stop), .pu(pu), .dr(dr), .mf(mf),
    .busy(busy), .init_done(init_done), .home_err(home_err),
    .pend_ovr(pend_ovr), .cur_pos(cur_pos)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int compared   = 0;
  int mismatched = 0;
  int modelPos[N_AXIS] = '{default: 0};

  // Observation counters, written only by the monitor below.
  int                riseCnt[N_AXIS]  = '{default: 0};
  int                lastRise[N_AXIS] = '{default: 0};
  bit                contig[N_AXIS]   = '{default: 1'b0};
  int                cycle       = 0;
  int                periodBad   = 0;
  int                mfMulti     = 0;
  int                pendOvrCnt  = 0;
  int                busyCycles  = 0;
  int                homeOrder[$];
  logic [N_AXIS-1:0] puPrev = '0;
  logic [N_AXIS-1:0] mfPrev = '0;

  // Count pulses and pulse periods, overwrite strobes, busy cycles and homing order.
  always @(negedge sysclk) begin
    cycle++;
    if (pend_ovr === 1'b1) pendOvrCnt++;
    if (busy === 1'b1) busyCycles++;
    if ($countones(mf) > 1) mfMulti++;
    for (int a = 0; a < N_AXIS; a++) begin
      if (mf[a] !== 1'b1) contig[a] = 1'b0;
      if (pu[a] === 1'b1 && puPrev[a] !== 1'b1) begin
        riseCnt[a]++;
        if (contig[a] && (cycle - lastRise[a]) != 2 * HALF_PER) periodBad++;
        lastRise[a] = cycle;
        contig[a]   = (mf[a] === 1'b1);
      end
    end
    if (mf !== mfPrev && mf != '0 && init_done !== 1'b1)
      for (int a = 0; a < N_AXIS; a++)
        if (mf[a] === 1'b1) homeOrder.push_back(a);
    puPrev = pu;
    mfPrev = mf;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Present one command strobe for a single clock.
  task automatic applyStimulus(input int axis, input int target);
    cmd_t c;
    c.axis     = AW'(axis);
    c.target   = POS_W'(target);
    cmd_valid  = 1'b1;
    cmd_axis   = c.axis;
    cmd_target = c.target;
    @(negedge sysclk);
    cmd_valid  = 1'b0;
  endtask

  function automatic int expTarget(input int target);
`ifdef POS_LIMIT_EN
    return (target > MAX_POS) ? MAX_POS : target;
`else
    return target;
`endif
  endfunction

  function automatic logic [N_AXIS*POS_W-1:0] packModel();
    logic [N_AXIS*POS_W-1:0] r;
    for (int a = 0; a < N_AXIS; a++) r[a*POS_W +: POS_W] = POS_W'(modelPos[a]);
    return r;
  endfunction

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 20000) checkOutput({tag, " idle timeout"}, 64'(busy), 64'd0);
  endtask

  // Absolute move compared against the position model: step count, direction, final positions.
  task automatic doMove(input int axis, input int target, input string tag);
    int   base    = riseCnt[axis];
    logic prevDr  = dr[axis];
    int   exp     = expTarget(target);
    int   diff    = exp - modelPos[axis];
    applyStimulus(axis, target);
    waitIdle(tag);
    modelPos[axis] = exp;
    checkOutput({tag, " cur_pos"}, 64'(cur_pos), 64'(packModel()));
    checkOutput({tag, " pulses"}, 64'(riseCnt[axis] - base), 64'((diff < 0) ? -diff : diff));
    checkOutput({tag, " dr"}, 64'(dr[axis]),
                (diff > 0) ? 64'd1 : (diff < 0) ? 64'd0 : 64'(prevDr));
  endtask

  // Homing run: release stop[k] after 5*(k+1) pulses, except on failAxis.
  task automatic homeRun(input int failAxis, input string tag);
    int base[N_AXIS];
    int ordBase = homeOrder.size();
    int n;
    for (int a = 0; a < N_AXIS; a++) base[a] = riseCnt[a];
    for (int k = 0; k < N_AXIS; k++) begin
      if (k == failAxis) continue;
      n = 0;
      while ((riseCnt[k] - base[k]) < 5 * (k + 1) && n < 20000) begin
        @(negedge sysclk);
        n++;
      end
      if (n >= 20000) checkOutput({tag, " pulse timeout"}, 64'(riseCnt[k] - base[k]), 64'(5 * (k + 1)));
      stop[k] = 1'b1;
      tick(20);
      stop[k] = 1'b0;
    end
    n = 0;
    while (init_done !== 1'b1 && n < 20000) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({tag, " init_done"}, 64'(init_done), 64'd1);
    checkOutput({tag, " home_err"}, 64'(home_err),
                (failAxis >= 0) ? (64'd1 << failAxis) : 64'd0);
    checkOutput({tag, " order count"}, 64'(homeOrder.size() - ordBase), 64'(N_AXIS));
    for (int k = 0; k < N_AXIS && ordBase + k < homeOrder.size(); k++)
      checkOutput({tag, " order"}, 64'(homeOrder[ordBase + k]), 64'(k));
    if (failAxis >= 0)
      checkOutput({tag, " timeout pulses"}, 64'(riseCnt[failAxis] - base[failAxis]), 64'(HOME_MAX));
  endtask

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, p, b, start;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_axis = '0; cmd_target = '0; stop = '0;
    tick(3);
    checkOutput("rst pu", 64'(pu), 64'd0);
    checkOutput("rst mf", 64'(mf), 64'd0);
    checkOutput("rst dr", 64'(dr), 64'd0);
    checkOutput("rst cur_pos", 64'(cur_pos), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd1);
    checkOutput("rst init_done", 64'(init_done), 64'd0);
    checkOutput("rst home_err", 64'(home_err), 64'd0);
    checkOutput("rst pend_ovr", 64'(pend_ovr), 64'd0);
    rst_n = 1'b1;

    homeRun(-1, "home1");
    waitIdle("home1");
    checkOutput("home1 busy", 64'(busy), 64'd0);
    checkOutput("home1 cur_pos", 64'(cur_pos), 64'd0);

    doMove(1, 10, "fwd10");
    doMove(1, 3, "rev3");
    b = busyCycles;
    doMove(1, 3, "same3");
    // Same-target command: one cycle with the slot full, one LOAD cycle.
    checkOutput("same3 busy cycles", 64'(busyCycles - b), 64'd2);

    b = busyCycles; p = pendOvrCnt;
    applyStimulus(7, 5);
    tick(3);
    checkOutput("bad axis busy", 64'(busyCycles - b), 64'd0);
    checkOutput("bad axis cur_pos", 64'(cur_pos), 64'(packModel()));

    doMove(0, 5, "ax0 to5");
    p = pendOvrCnt; base = riseCnt[0];
    applyStimulus(0, 9);
    tick(3);
    applyStimulus(0, 7);
    applyStimulus(0, 5);
    waitIdle("ovr");
    checkOutput("ovr pend_ovr", 64'(pendOvrCnt - p), 64'd1);
    checkOutput("ovr pulses", 64'(riseCnt[0] - base), 64'd8);
    checkOutput("ovr cur_pos", 64'(cur_pos), 64'(packModel()));
    checkOutput("ovr dr", 64'(dr[0]), 64'd0);

    p = pendOvrCnt; base = riseCnt[0];
    applyStimulus(0, 12);
    tick(1);
    applyStimulus(0, 2);
    waitIdle("same-cycle");
    modelPos[0] = 2;
    checkOutput("same-cycle pend_ovr", 64'(pendOvrCnt - p), 64'd0);
    checkOutput("same-cycle pulses", 64'(riseCnt[0] - base), 64'd17);
    checkOutput("same-cycle cur_pos", 64'(cur_pos), 64'(packModel()));

    for (int i = 0; i < 6; i++)
      doMove(int'($urandom_range(0, N_AXIS - 1)), int'($urandom_range(0, 60)), "random");

    doMove(3, 30, "ax3 to30");
    base = riseCnt[3];
    applyStimulus(3, 2);
    for (int n = 0; n < 2000 && (riseCnt[3] - base) < 5; n++) @(negedge sysclk);
    stop[3] = 1'b1;
    tick(4);
    stop[3] = 1'b0;
    waitIdle("rev abort");
    modelPos[3] = 0;
    checkOutput("rev abort cur_pos", 64'(cur_pos), 64'(packModel()));
    checkOutput("rev abort early", 64'((riseCnt[3] - base) < 28), 64'd1);

    start = modelPos[4]; base = riseCnt[4];
    applyStimulus(4, start + 20);
    for (int n = 0; n < 2000 && (riseCnt[4] - base) < 3; n++) @(negedge sysclk);
    stop[4] = 1'b1;
    tick(5);
    stop[4] = 1'b0;
    waitIdle("fwd stop");
    modelPos[4] = start + 20;
    checkOutput("fwd stop pulses", 64'(riseCnt[4] - base), 64'd20);
    checkOutput("fwd stop cur_pos", 64'(cur_pos), 64'(packModel()));

    doMove(0, 900, "long900");
    doMove(5, 1023, "max1023");
    checkOutput("pulse period", 64'(periodBad), 64'd0);
    checkOutput("mf one-hot", 64'(mfMulti), 64'd0);

    applyStimulus(2, 200);
    tick(30);
    rst_n = 1'b0;
    @(negedge sysclk);
    checkOutput("midrst pu", 64'(pu), 64'd0);
    checkOutput("midrst mf", 64'(mf), 64'd0);
    checkOutput("midrst cur_pos", 64'(cur_pos), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd1);
    checkOutput("midrst init_done", 64'(init_done), 64'd0);
    tick(2);
    rst_n = 1'b1;
    for (int a = 0; a < N_AXIS; a++) modelPos[a] = 0;

    applyStimulus(4, 15);
    homeRun(2, "home2");
    waitIdle("home2 queued");
    modelPos[4] = 15;
    checkOutput("home2 queued cur_pos", 64'(cur_pos), 64'(packModel()));
    checkOutput("home2 busy", 64'(busy), 64'd0);
    checkOutput("home2 mf one-hot", 64'(mfMulti), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
